complex_mtx_mul_seq: RTL and testbench
======================================

COMPLEX_MTX_MUL_SEQ -- requirements
Module: complex_mtx_mul_seq

Interface
REQ-001 Parameter WIDTH, default 37: signed two's-complement width of each real or imaginary component.
REQ-002 Parameter FRAC, default 35: number of fractional bits in each component; range 0 to WIDTH-2.
REQ-003 Parameter N, default 2: matrix dimension; legal values 2 and 4.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port mtx_a, input, N*N*2*WIDTH bits: left operand; element (r,c,k) at bit offset ((r*N+c)*2+k)*WIDTH; k=0 real, k=1 imaginary.
REQ-007 Port mtx_b, input, N*N*2*WIDTH bits: right operand, packed as mtx_a.
REQ-008 Port conj_b, input, 1 bit: 1 selects the conjugate transpose of mtx_b as the right operand.
REQ-009 Port in_valid, input, 1 bit: operands and conj_b are valid.
REQ-010 Port in_ready, output, 1 bit: the block accepts operands.
REQ-011 Port mtx_r, output, N*N*2*WIDTH bits: result, packed as mtx_a.
REQ-012 Port out_valid, output, 1 bit: mtx_r holds a completed result.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 Port overflow, output, 1 bit: at least one element of the current result saturated.

Function
REQ-015 The FSM SHALL have three states: IDLE, MAC and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE), both registered.
REQ-016 In IDLE, in_valid=1 SHALL register mtx_a, mtx_b and conj_b, clear overflow, zero the index counter and enter MAC; the inputs are don't-care afterwards.
REQ-017 MAC SHALL perform one complex multiply-accumulate per cycle over index (r,c,i), with i the fastest-changing field and r the slowest, for exactly N^3 cycles.
REQ-018 Operand selection: a=A[r][i]; b=B[i][c] if conj_b=0, otherwise b=(B[c][i].re, -B[c][i].im).
REQ-019 Product: re=a.re*b.re-a.im*b.im and im=a.re*b.im+a.im*b.re, both at full precision (2*WIDTH+1 bits); negation of the most negative value SHALL not wrap (use a widened operand).
REQ-020 The accumulator width SHALL be 2*WIDTH+1+log2(N); it loads the product when i=0 and adds the product otherwise.
REQ-021 When i=N-1, each component SHALL be rounded half-up (add 2^(FRAC-1), arithmetic shift right by FRAC) and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1], then written to mtx_r(r,c).
REQ-022 Any saturation SHALL set the sticky overflow bit for the current result.
REQ-023 The edge that writes the last element (r=c=i=N-1) SHALL move the FSM to DONE.
REQ-024 Latency: operands accepted on edge k give out_valid=1 after edge k+N^3.
REQ-025 In DONE, mtx_r and overflow SHALL stay stable until out_ready=1, which returns the FSM to IDLE on that edge.
REQ-026 in_valid in MAC or DONE SHALL be ignored, with no state change.
REQ-027 The earliest next acceptance after DONE is one cycle after the handshake.
REQ-028 Elements of mtx_r not yet rewritten during MAC hold their previous values; mtx_r is only guaranteed valid while out_valid=1.

Reset
REQ-029 reset=1 SHALL force IDLE, in_ready=1, out_valid=0, overflow=0, mtx_r=0 and the index counter to 0 on the next edge, from any state.
REQ-030 reset asserted mid-MAC SHALL abort the operation, producing no out_valid pulse.
REQ-031 reset SHALL take priority over in_valid and out_ready in the same cycle.

Verification (WIDTH=16, FRAC=14, N=2, so 1.0=16384)
REQ-032 A=I, B=[[1+2i, 3],[-4i, 0.5]], conj_b=0 -> mtx_r=B exactly, overflow=0, out_valid exactly 8 cycles after acceptance.
REQ-033 A=B=H with all entries 11585 (1/sqrt2) except B[1][1]=A[1][1]=-11585 -> diagonal=16383, off-diagonal=0, overflow=0.
REQ-034 A=I, B=[[0, i],[0, 0]], conj_b=1 -> mtx_r(1,0).im=-16384 and all other components 0.
REQ-035 A=B=32767*I -> diagonal real=32767 (saturated), overflow=1; result held while out_ready is low for 5 cycles, then IDLE one edge after out_ready=1.
REQ-036 reset asserted 3 cycles into MAC -> next cycle in_ready=1, out_valid=0, mtx_r=0; a following transaction gives correct results.
REQ-037 in_valid held high continuously with out_ready=1 -> one acceptance every N^3+2 cycles, with no transaction lost or duplicated.

Source files
------------

// File: rtl/complex_mtx_mul_seq.sv
// Sequential NxN complex matrix multiply (B optionally conjugate-transposed), one complex MAC per cycle.
// Latency N^3 cycles from acceptance to out_valid; result held until out_ready, one operation in flight.
module complex_mtx_mul_seq #(
   parameter int WIDTH = 37,
   parameter int FRAC  = 35,
   parameter int N     = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N*N*2*WIDTH-1:0] mtx_a,
   input  logic [N*N*2*WIDTH-1:0] mtx_b,
   input  logic                   conj_b,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [N*N*2*WIDTH-1:0] mtx_r,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   overflow
);
   localparam int NE  = N * N;
   localparam int LGN = $clog2(N);
   localparam int CW  = 3 * LGN;
   localparam int AW  = 2 * WIDTH + 1 + LGN;
   localparam int MW  = NE * 2 * WIDTH;

   localparam logic signed [AW-1:0] RND_K   = (AW'(1) << FRAC) >> 1;
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                  state_q;
   logic [MW-1:0]           a_q;
   logic [MW-1:0]           b_q;
   logic                    conj_q;
   logic [CW-1:0]           idx_q;
   logic signed [AW-1:0]    acc_re_q;
   logic signed [AW-1:0]    acc_im_q;
   logic signed [WIDTH-1:0] res_re_q [NE];
   logic signed [WIDTH-1:0] res_im_q [NE];
   logic                    ovf_q;
   logic                    in_ready_q;
   logic                    out_valid_q;

   logic signed [WIDTH-1:0] a_re_v [NE];
   logic signed [WIDTH-1:0] a_im_v [NE];
   logic signed [WIDTH-1:0] b_re_v [NE];
   logic signed [WIDTH-1:0] b_im_v [NE];

   logic [LGN-1:0]          f_r;
   logic [LGN-1:0]          f_c;
   logic [LGN-1:0]          f_i;
   logic [2*LGN-1:0]        a_sel;
   logic [2*LGN-1:0]        b_sel;
   logic [2*LGN-1:0]        w_sel;

   logic signed [AW-1:0]    ar_x;
   logic signed [AW-1:0]    ai_x;
   logic signed [AW-1:0]    br_x;
   logic signed [AW-1:0]    bi_x;
   logic signed [AW-1:0]    prod_re;
   logic signed [AW-1:0]    prod_im;
   logic signed [AW-1:0]    acc_re_d;
   logic signed [AW-1:0]    acc_im_d;
   logic [WIDTH:0]          sat_re;
   logic [WIDTH:0]          sat_im;

   function automatic logic signed [AW-1:0] sext(input logic signed [WIDTH-1:0] v);
      return {{(AW-WIDTH){v[WIDTH-1]}}, v};
   endfunction

   // Returns {saturated, value}; the accumulator has headroom so the rounding add cannot wrap.
   function automatic logic [WIDTH:0] round_sat(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] s;
      s = (v + RND_K) >>> FRAC;
      if (s > SAT_MAX) begin
         round_sat = {1'b1, SAT_MAX[WIDTH-1:0]};
      end else if (s < SAT_MIN) begin
         round_sat = {1'b1, SAT_MIN[WIDTH-1:0]};
      end else begin
         round_sat = {1'b0, s[WIDTH-1:0]};
      end
   endfunction

   for (genvar e = 0; e < NE; e++) begin : g_view
      assign a_re_v[e] = a_q[(2*e)*WIDTH +: WIDTH];
      assign a_im_v[e] = a_q[(2*e+1)*WIDTH +: WIDTH];
      assign b_re_v[e] = b_q[(2*e)*WIDTH +: WIDTH];
      assign b_im_v[e] = b_q[(2*e+1)*WIDTH +: WIDTH];
      assign mtx_r[(2*e)*WIDTH +: WIDTH]   = res_re_q[e];
      assign mtx_r[(2*e+1)*WIDTH +: WIDTH] = res_im_q[e];
   end

   // N is a power of two, so {row, col} is directly the flat element index.
   assign f_r   = idx_q[CW-1 -: LGN];
   assign f_c   = idx_q[2*LGN-1 -: LGN];
   assign f_i   = idx_q[LGN-1:0];
   assign a_sel = {f_r, f_i};
   assign b_sel = conj_q ? {f_c, f_i} : {f_i, f_c};
   assign w_sel = {f_r, f_c};

   always_comb begin
      ar_x = sext(a_re_v[a_sel]);
      ai_x = sext(a_im_v[a_sel]);
      br_x = sext(b_re_v[b_sel]);
      // Negating in the widened domain keeps the most negative value from wrapping.
      bi_x = conj_q ? -sext(b_im_v[b_sel]) : sext(b_im_v[b_sel]);
      prod_re  = ar_x * br_x - ai_x * bi_x;
      prod_im  = ar_x * bi_x + ai_x * br_x;
      acc_re_d = (f_i == '0) ? prod_re : acc_re_q + prod_re;
      acc_im_d = (f_i == '0) ? prod_im : acc_im_q + prod_im;
      sat_re   = round_sat(acc_re_d);
      sat_im   = round_sat(acc_im_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         idx_q       <= '0;
         for (int e = 0; e < NE; e++) begin
            res_re_q[e] <= '0;
            res_im_q[e] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= mtx_a;
                  b_q        <= mtx_b;
                  conj_q     <= conj_b;
                  ovf_q      <= 1'b0;
                  idx_q      <= '0;
                  state_q    <= MAC;
                  in_ready_q <= 1'b0;
               end
            end
            MAC: begin
               acc_re_q <= acc_re_d;
               acc_im_q <= acc_im_d;
               idx_q    <= idx_q + CW'(1);
               if (f_i == '1) begin
                  res_re_q[w_sel] <= sat_re[WIDTH-1:0];
                  res_im_q[w_sel] <= sat_im[WIDTH-1:0];
                  if (sat_re[WIDTH] || sat_im[WIDTH]) begin
                     ovf_q <= 1'b1;
                  end
               end
               if (idx_q == '1) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_complex_mtx_mul_seq.sv
// Directed bench for complex_mtx_mul_seq at WIDTH=16, FRAC=14, N=2 (1.0 = 16384).
module tb_complex_mtx_mul_seq;
   localparam int MW = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic [MW-1:0] mtx_a;
   logic [MW-1:0] mtx_b;
   logic          conj_b;
   logic          in_valid;
   logic          in_ready;
   logic [MW-1:0] mtx_r;
   logic          out_valid;
   logic          out_ready;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   complex_mtx_mul_seq #(.WIDTH(16), .FRAC(14), .N(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .mtx_a    (mtx_a),
      .mtx_b    (mtx_b),
      .conj_b   (conj_b),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mtx_r    (mtx_r),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overflow (overflow)
   );

   // Arguments in element order (0,0) (0,1) (1,0) (1,1), real then imaginary.
   function automatic logic [MW-1:0] mk(input int e00r, input int e00i, input int e01r, input int e01i,
                                        input int e10r, input int e10i, input int e11r, input int e11i);
      return {16'(e11i), 16'(e11r), 16'(e10i), 16'(e10r), 16'(e01i), 16'(e01r), 16'(e00i), 16'(e00r)};
   endfunction

   task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation, keep in_valid high with junk operands for a few MAC cycles,
   // then check latency, result, overflow, hold behaviour and the return to IDLE.
   task automatic run_txn(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input logic cj, input logic [MW-1:0] exp, input logic eovf, input int hold);
      int lat;
      chk({tag, "_rdy"}, in_ready, 1);
      mtx_a    = a;
      mtx_b    = b;
      conj_b   = cj;
      in_valid = 1'b1;
      tick();
      mtx_a  = '1;
      mtx_b  = ~b;
      conj_b = ~cj;
      chk({tag, "_busy"}, in_ready, 0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         if (lat == 3) in_valid = 1'b0;
         tick();
         lat++;
      end
      in_valid = 1'b0;
      chk({tag, "_lat"}, lat, 8);
      chk({tag, "_res"}, mtx_r, exp);
      chk({tag, "_ovf"}, overflow, eovf);
      for (int k = 0; k < hold; k++) begin
         tick();
         chk({tag, "_hold_vld"}, out_valid, 1);
         chk({tag, "_hold_res"}, mtx_r, exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_idle_rdy"}, in_ready, 1);
      chk({tag, "_idle_vld"}, out_valid, 0);
   endtask

   logic [MW-1:0] ident;
   logic [MW-1:0] hmat;
   logic [MW-1:0] cont_b [3];

   initial begin
      int  cyc;
      int  last_acc;
      int  nacc;
      int  nout;
      logic acc;
      logic seen;

      ident = mk(16384, 0, 0, 0, 0, 0, 16384, 0);
      hmat  = mk(11585, 0, 11585, 0, 11585, 0, -11585, 0);

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      conj_b    = 1'b0;
      mtx_a     = '0;
      mtx_b     = '0;
      tick();
      tick();
      chk("rst_rdy", in_ready, 1);
      chk("rst_vld", out_valid, 0);
      chk("rst_res", mtx_r, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
      tick();

      // Integer entries are raw LSBs; 0.5 is 8192.
      run_txn("ident", ident, mk(1, 2, 3, 0, 0, -4, 8192, 0), 1'b0,
              mk(1, 2, 3, 0, 0, -4, 8192, 0), 1'b0, 0);
      run_txn("satpos", mk(32767, 0, 0, 0, 0, 0, 32767, 0), mk(32767, 0, 0, 0, 0, 0, 32767, 0), 1'b0,
              mk(32767, 0, 0, 0, 0, 0, 32767, 0), 1'b1, 5);
      run_txn("hadam", hmat, hmat, 1'b0, mk(16383, 0, 0, 0, 0, 0, 16383, 0), 1'b0, 0);
      run_txn("conj", ident, mk(0, 0, 0, 16384, 0, 0, 0, 0), 1'b1,
              mk(0, 0, 0, 0, 0, -16384, 0, 0), 1'b0, 1);
      run_txn("satneg", mk(-32768, 0, 0, 0, 0, 0, -32768, 0), mk(32767, 0, 0, 0, 0, 0, 32767, 0), 1'b0,
              mk(-32768, 0, 0, 0, 0, 0, -32768, 0), 1'b1, 0);
      run_txn("conjmin", ident, mk(0, 0, 0, -32768, 0, 0, 0, 0), 1'b1,
              mk(0, 0, 0, 0, 0, 32767, 0, 0), 1'b1, 0);

      // Abort three cycles into MAC; in_valid also high during reset.
      mtx_a    = mk(32767, 0, 0, 0, 0, 0, 32767, 0);
      mtx_b    = mtx_a;
      conj_b   = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      reset    = 1'b1;
      in_valid = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("abort_rdy", in_ready, 1);
      chk("abort_vld", out_valid, 0);
      chk("abort_res", mtx_r, 0);
      chk("abort_ovf", overflow, 0);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid === 1'b1) seen = 1'b1;
      end
      chk("abort_nopulse", seen, 0);
      run_txn("after_abort", ident, mk(1, 2, 3, 0, 0, -4, 8192, 0), 1'b0,
              mk(1, 2, 3, 0, 0, -4, 8192, 0), 1'b0, 0);

      // Back-to-back traffic with in_valid and out_ready held high.
      for (int k = 0; k < 3; k++) begin
         cont_b[k] = mk(100 * (k + 1), k + 1, 7 * k, 0, 0, -3 * k, -50 * (k + 1), 0);
      end
      mtx_a     = ident;
      conj_b    = 1'b0;
      mtx_b     = cont_b[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cyc       = 0;
      last_acc  = 0;
      nacc      = 0;
      nout      = 0;
      for (int t = 0; t < 80 && nout < 3; t++) begin
         acc = in_ready && in_valid;
         tick();
         cyc++;
         if (acc) begin
            if (nacc > 0) chk("cont_gap", cyc - last_acc, 10);
            last_acc = cyc;
            nacc++;
            if (nacc < 3) mtx_b = cont_b[nacc];
            else in_valid = 1'b0;
         end
         if (out_valid === 1'b1) begin
            if (nout < 3) chk("cont_res", mtx_r, cont_b[nout]);
            nout++;
         end
      end
      in_valid  = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid === 1'b1) nout++;
      end
      out_ready = 1'b0;
      chk("cont_acc", nacc, 3);
      chk("cont_out", nout, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
